// File: rtl/ov7670_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_pkg
// Shared constants and types for the OV7670 SCCB power-up configuration
// controller.
//   SCCB_WR_ID    : 8-bit SCCB write address of the OV7670 (0x42)
//   N_REGS        : number of entries in the configuration table
//   REG_*         : addresses of the sensor registers the table names
//   FRAME_BITS    : bit slots in one SCCB 3-phase write
//   sccb_state_t  : controller FSM states
//   sccb_frame()  : packs a {addr,data} table entry into the 27-slot frame
// ----------------------------------------------------------------------------
package ov7670_pkg;

    localparam logic [7:0] SCCB_WR_ID = 8'h42;
    localparam int         N_REGS     = 10;
    localparam int         FRAME_BITS = 27;

    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_CLKRC  = 8'h11;
    localparam logic [7:0] REG_TSLB   = 8'h3A;
    localparam logic [7:0] REG_COM13  = 8'h3D;

    typedef enum logic [2:0] {
        BOOT_WAIT,
        LOAD,
        START,
        BITS,
        STOP,
        WAIT,
        DONE
    } sccb_state_t;

    // Released (don't-care) slots are encoded as 1 so the driver simply
    // lets go of SIOD there (oe = ~bit).
    function automatic logic [FRAME_BITS-1:0] sccb_frame(input logic [15:0] entry);
        return {SCCB_WR_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// ----------------------------------------------------------------------------
// ov7670_reg_rom
// Configuration table: QVGA, YUV 4:2:2, Y U Y V ordering.
// Ports:
//   idx_i   [5:0]  table index
//   entry_o [15:0] {register address, register data}; 16'hFFFF past the end
// ----------------------------------------------------------------------------
module ov7670_reg_rom
    import ov7670_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [15:0] entry_o
);

    always_comb begin
        entry_o = 16'hFFFF;
        case (idx_i)
            6'd0:    entry_o = {REG_COM7,  8'h80};  // soft reset, must stay first
            6'd1:    entry_o = {REG_COM7,  8'h10};  // QVGA, YUV
            6'd2:    entry_o = {REG_CLKRC, 8'h01};
            6'd3:    entry_o = {REG_TSLB,  8'h04};  // bit 3 = 0 -> Y U Y V order
            6'd4:    entry_o = {REG_COM13, 8'h88};  // bit 0 = 0 -> Y U Y V order
            6'd5:    entry_o = 16'h0C04;
            6'd6:    entry_o = 16'h3E19;
            6'd7:    entry_o = 16'h7211;
            6'd8:    entry_o = 16'h73F1;
            6'd9:    entry_o = 16'h40C0;
            default: entry_o = 16'hFFFF;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// ----------------------------------------------------------------------------
// ov7670_sccb_config
// Power-up configuration controller for the OV7670. After reset it waits,
// then writes every table entry over SCCB (write-only, ACK ignored) and
// raises cfg_done. Runs on the system clock.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   restart   one-cycle pulse, reruns the table; honoured only in DONE
//   sioc      SCCB clock (push-pull)
//   siod_oe   1 = pull SIOD low, 0 = release
//   siod_in   SIOD pad readback, observed only
//   busy      high from boot wait until the table completes
//   cfg_done  high once the last entry has been written
//   reg_idx   table entry currently in flight
// ----------------------------------------------------------------------------
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int CLK_HZ         = 48_000_000,
    parameter int SCCB_HZ        = 100_000,
    parameter int BOOT_WAIT_CYC  = 48_000,
    parameter int SWRST_WAIT_CYC = 48_000,
    parameter int GAP_CYC        = 480
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    output logic       sioc,
    output logic       siod_oe,
    input  logic       siod_in,
    output logic       busy,
    output logic       cfg_done,
    output logic [5:0] reg_idx
);

    // Quarter-bit divider
    localparam int DIV_RAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // One wait counter serves boot, post-soft-reset and inter-write gaps
    localparam int WAIT_MAX_A = (BOOT_WAIT_CYC > SWRST_WAIT_CYC) ? BOOT_WAIT_CYC : SWRST_WAIT_CYC;
    localparam int WAIT_MAX   = (WAIT_MAX_A > GAP_CYC) ? WAIT_MAX_A : GAP_CYC;
    localparam int WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] BOOT_LAST  = WAIT_W'(BOOT_WAIT_CYC - 1);
    localparam logic [WAIT_W-1:0] SWRST_LAST = WAIT_W'(SWRST_WAIT_CYC - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYC - 1);

    localparam logic [5:0] LAST_IDX = 6'(N_REGS - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  tick;

    sccb_state_t           state_q;
    logic                  sioc_q;
    logic                  siod_oe_q;
    logic                  busy_q;
    logic                  cfg_done_q;
    logic [5:0]            reg_idx_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [4:0]            bit_cnt_q;
    logic [1:0]            qtr_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [1:0]            siod_sync_q;
    logic                  nack_q;

    logic [15:0]           rom_entry;
    logic [WAIT_W-1:0]     wait_last;
    logic                  ack_slot;

    ov7670_reg_rom u_rom (
        .idx_i   (reg_idx_q),
        .entry_o (rom_entry)
    );

    // Free-running divider; every bus edge is aligned to its tick
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // The sensor needs a much longer settle time after the COM7 soft reset
    assign wait_last = (reg_idx_q == 6'd0) ? SWRST_LAST : GAP_LAST;

    // Slots 9/18/27 are where the sensor would acknowledge
    assign ack_slot  = (bit_cnt_q == 5'd8) || (bit_cnt_q == 5'd17) || (bit_cnt_q == 5'd26);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT_WAIT;
            sioc_q      <= 1'b1;
            siod_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            reg_idx_q   <= '0;
            wait_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            qtr_q       <= '0;
            frame_q     <= '0;
            siod_sync_q <= 2'b11;
            nack_q      <= 1'b0;
        end else begin
            siod_sync_q <= {siod_sync_q[0], siod_in};

            case (state_q)
                BOOT_WAIT: begin
                    busy_q    <= 1'b1;
                    sioc_q    <= 1'b1;
                    siod_oe_q <= 1'b0;
                    if (wait_cnt_q == BOOT_LAST) begin
                        wait_cnt_q <= '0;
                        state_q    <= LOAD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                LOAD: begin
                    frame_q   <= sccb_frame(rom_entry);
                    bit_cnt_q <= '0;
                    qtr_q     <= '0;
                    nack_q    <= 1'b0;
                    state_q   <= START;
                end

                // SIOD falls while SIOC is high, then SIOC drops
                START: begin
                    if (tick) begin
                        if (qtr_q == 2'd0) begin
                            siod_oe_q <= 1'b1;
                            qtr_q     <= 2'd1;
                        end else begin
                            sioc_q    <= 1'b0;
                            qtr_q     <= 2'd0;
                            bit_cnt_q <= '0;
                            state_q   <= BITS;
                        end
                    end
                end

                // Data changes at q0 with SIOC low; SIOC high for q2..q3
                BITS: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: begin
                                sioc_q    <= 1'b0;
                                siod_oe_q <= ~frame_q[FRAME_BITS-1];
                            end
                            2'd1: sioc_q <= 1'b0;
                            2'd2: sioc_q <= 1'b1;
                            default: begin
                                sioc_q  <= 1'b1;
                                frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                                // Debug only: a high SIOD in an ACK slot is a NACK
                                if (ack_slot) begin
                                    nack_q <= nack_q | siod_sync_q[1];
                                end
                                if (bit_cnt_q == LAST_BIT) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= STOP;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 5'd1;
                                end
                            end
                        endcase
                    end
                end

                // SIOD low with SIOC low, raise SIOC, then release SIOD
                STOP: begin
                    if (tick) begin
                        case (qtr_q)
                            2'd0: begin
                                sioc_q    <= 1'b0;
                                siod_oe_q <= 1'b1;
                                qtr_q     <= 2'd1;
                            end
                            2'd1: begin
                                sioc_q <= 1'b1;
                                qtr_q  <= 2'd2;
                            end
                            default: begin
                                siod_oe_q  <= 1'b0;
                                qtr_q      <= '0;
                                wait_cnt_q <= '0;
                                state_q    <= WAIT;
                            end
                        endcase
                    end
                end

                WAIT: begin
                    if (wait_cnt_q == wait_last) begin
                        wait_cnt_q <= '0;
                        if (reg_idx_q == LAST_IDX) begin
                            cfg_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            reg_idx_q <= reg_idx_q + 6'd1;
                            state_q   <= LOAD;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                // restart is only looked at here, so it is ignored while busy
                DONE: begin
                    if (restart) begin
                        cfg_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        reg_idx_q  <= '0;
                        wait_cnt_q <= '0;
                        state_q    <= BOOT_WAIT;
                    end
                end

                default: begin
                    state_q <= BOOT_WAIT;
                end
            endcase
        end
    end

    assign sioc     = sioc_q;
    assign siod_oe  = siod_oe_q;
    assign busy     = busy_q;
    assign cfg_done = cfg_done_q;
    assign reg_idx  = reg_idx_q;

endmodule
